// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Includes the operand width, the op encodings and the FSM state type.
package muldiv_ctrl_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL     = 3'd1,
    ST_DIV_RUN = 3'd2,
    ST_DIV_FIX = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, then subtract the
// divisor from the remainder only if the result does not go negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_partial;
  logic [W:0] w_diff;

  // rem < divisor always holds, so the W+1 bit difference cannot wrap and its MSB is the borrow
  assign w_partial = {i_rem, i_quo[W-1]};
  assign w_diff    = w_partial - {1'b0, i_divisor};

  always_comb begin
    o_rem = w_partial[W-1:0];
    o_quo = {i_quo[W-2:0], 1'b0};
    if (!w_diff[W]) begin
      o_rem = w_diff[W-1:0];
      o_quo = {i_quo[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for mult/multu/div/divu: single-cycle multiply and iterative restoring
// divide, with pipeline stall request and a one-cycle done pulse.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  input  logic             i_cancel,
  output logic             o_stall_req,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_rem, r_quo, r_opb;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed, r_negq, r_negr, r_div_zero;

  logic               w_is_div, w_opb_zero, w_last_step, w_stall;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic signed [WIDTH:0]     w_ma, w_mb;
  logic signed [2*WIDTH-1:0] w_prod;

  assign w_is_div    = i_op[1];
  assign w_opb_zero  = (i_opb == '0);
  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

  // Signed divide works on magnitudes; multiply keeps raw operands
  assign w_abs_a = (i_op == MD_DIV && i_opa[WIDTH-1]) ? (~i_opa + 1'b1) : i_opa;
  assign w_abs_b = (i_op == MD_DIV && i_opb[WIDTH-1]) ? (~i_opb + 1'b1) : i_opb;

  // r_quo doubles as the latched multiplicand while in MUL
  assign w_ma   = {r_signed & r_quo[WIDTH-1], r_quo};
  assign w_mb   = {r_signed & r_opb[WIDTH-1], r_opb};
  assign w_prod = $signed({{(WIDTH-1){w_ma[WIDTH]}}, w_ma}) *
                  $signed({{(WIDTH-1){w_mb[WIDTH]}}, w_mb});

  div_step #(.W(WIDTH)) u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_opb),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = i_start;
        if (i_start) begin
          if (!w_is_div)       w_next = ST_MUL;
          else if (w_opb_zero) w_next = ST_DONE;
          else                 w_next = ST_DIV_RUN;
        end
      end
      ST_MUL: begin
        w_stall = 1'b1;
        w_next  = ST_DONE;
      end
      ST_DIV_RUN: begin
        w_stall = 1'b1;
        if (w_last_step) w_next = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        w_stall = 1'b1;
        w_next  = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_cancel) w_next = ST_IDLE;
  end

  // A flush freezes every datapath register, so hi/lo/div_zero survive an abort untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_opb      <= '0;
      r_cnt      <= '0;
      r_signed   <= 1'b0;
      r_negq     <= 1'b0;
      r_negr     <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (!i_cancel) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_opb      <= w_abs_b;
            r_cnt      <= '0;
            r_signed   <= (i_op == MD_MULT);
            r_negq     <= (i_op == MD_DIV) && (i_opa[WIDTH-1] ^ i_opb[WIDTH-1]);
            r_negr     <= (i_op == MD_DIV) && i_opa[WIDTH-1];
            r_div_zero <= w_is_div && w_opb_zero;
            if (w_is_div && w_opb_zero) begin
              r_hi <= i_opa;
              r_lo <= '1;
            end
          end
        end
        ST_MUL: begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
        ST_DIV_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_DIV_FIX: begin
          r_lo <= r_negq ? (~r_quo + 1'b1) : r_quo;
          r_hi <= r_negr ? (~r_rem + 1'b1) : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign o_stall_req = w_stall & ~rst;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl: results, latencies, stall window, cancel,
// divide-by-zero flag and asynchronous reset.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_opa;
  logic [31:0] i_opb;
  logic        i_cancel;
  logic        o_stall_req;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_div_zero;

  int total = 0;
  int bad   = 0;

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_opa       (i_opa),
    .i_opb       (i_opb),
    .i_cancel    (i_cancel),
    .o_stall_req (o_stall_req),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo),
    .o_div_zero  (o_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op in the cycle after the next negedge (cycle t) and follows it until done
  // or a 60-cycle limit. ev_kind 1 raises cancel in cycle t+ev_cyc, 2 raises a stray start.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ev_cyc, input int ev_kind,
                        output int lat, output int stalls, output logic got_done);
    @(negedge clk);
    i_op = op; i_opa = a; i_opb = b; i_start = 1'b1; i_cancel = 1'b0;
    #1;
    stalls   = o_stall_req ? 1 : 0;
    lat      = 0;
    got_done = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      i_start  = 1'b0;
      i_cancel = 1'b0;
      if (lat == ev_cyc) begin
        if (ev_kind == 1) i_cancel = 1'b1;
        else if (ev_kind == 2) begin
          i_start = 1'b1; i_op = MD_MULTU; i_opa = 32'd3; i_opb = 32'd3;
        end
      end
      #1;
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
      if (o_stall_req) stalls++;
    end
    i_start  = 1'b0;
    i_cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b1; i_op = MD_DIVU; i_opa = 32'd5; i_opb = 32'd0; i_cancel = 1'b0;
    #12;
    total++;
    if ({o_hi, o_lo, o_done, o_div_zero, o_stall_req} !== 67'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got hi=%h lo=%h done=%b dz=%b stall=%b, want all 0",
               o_hi, o_lo, o_done, o_div_zero, o_stall_req);
    end
    @(negedge clk);
    i_start = 1'b0;
    rst     = 1'b0;
    #1;
    total++;
    if (o_stall_req !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got stall=%b done=%b, want 0 0", o_stall_req, o_done);
    end
  endtask

  task automatic test_mult();
    int lat, stalls; logic got;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, lat, stalls, got);
    total++;
    if (lat !== 2 || stalls !== 2) begin
      bad++; $display("[TB] FAIL mult_latency: got lat=%0d stalls=%0d, want 2 2", lat, stalls);
    end
    total++;
    if (o_hi !== 32'hFFFF_FFFF || o_lo !== 32'hFFFF_FFFA || o_stall_req !== 1'b0) begin
      bad++; $display("[TB] FAIL mult_result: got hi=%h lo=%h stall=%b, want ffffffff fffffffa 0",
                      o_hi, o_lo, o_stall_req);
    end
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, lat, stalls, got);
    total++;
    if (o_hi !== 32'h4000_0000 || o_lo !== 32'h0) begin
      bad++; $display("[TB] FAIL mult_minmin: got hi=%h lo=%h, want 40000000 00000000", o_hi, o_lo);
    end
  endtask

  task automatic test_multu();
    int lat, stalls; logic got;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, stalls, got);
    total++;
    if (lat !== 2 || o_hi !== 32'hFFFF_FFFE || o_lo !== 32'h0000_0001) begin
      bad++; $display("[TB] FAIL multu_result: got lat=%0d hi=%h lo=%h, want 2 fffffffe 00000001",
                      lat, o_hi, o_lo);
    end
  endtask

  task automatic test_div_signed();
    int lat, stalls; logic got;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, stalls, got);
    total++;
    if (lat !== 34 || stalls !== 34 || o_stall_req !== 1'b0) begin
      bad++; $display("[TB] FAIL div_timing: got lat=%0d stalls=%0d stall_at_done=%b, want 34 34 0",
                      lat, stalls, o_stall_req);
    end
    total++;
    if (o_lo !== 32'hFFFF_FFFD || o_hi !== 32'hFFFF_FFFF || o_div_zero !== 1'b0) begin
      bad++; $display("[TB] FAIL div_neg7_2: got lo=%h hi=%h dz=%b, want fffffffd ffffffff 0",
                      o_lo, o_hi, o_div_zero);
    end
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, lat, stalls, got);
    total++;
    if (o_lo !== 32'hFFFF_FFFD || o_hi !== 32'h0000_0001) begin
      bad++; $display("[TB] FAIL div_7_neg2: got lo=%h hi=%h, want fffffffd 00000001", o_lo, o_hi);
    end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, stalls, got);
    total++;
    if (o_lo !== 32'h8000_0000 || o_hi !== 32'h0 || o_div_zero !== 1'b0) begin
      bad++; $display("[TB] FAIL div_overflow: got lo=%h hi=%h dz=%b, want 80000000 00000000 0",
                      o_lo, o_hi, o_div_zero);
    end
  endtask

  task automatic test_div_zero();
    int lat, stalls; logic got;
    run_op(MD_DIVU, 32'd100, 32'd0, 0, 0, lat, stalls, got);
    total++;
    if (lat !== 1 || stalls !== 1 || o_div_zero !== 1'b1 || o_hi !== 32'd100 || o_lo !== 32'hFFFF_FFFF) begin
      bad++; $display("[TB] FAIL divzero: got lat=%0d stalls=%0d dz=%b hi=%h lo=%h, want 1 1 1 00000064 ffffffff",
                      lat, stalls, o_div_zero, o_hi, o_lo);
    end
    @(negedge clk);
    #1;
    total++;
    if (o_div_zero !== 1'b1 || o_done !== 1'b0) begin
      bad++; $display("[TB] FAIL divzero_hold: got dz=%b done=%b, want 1 0", o_div_zero, o_done);
    end
    run_op(MD_MULTU, 32'd5, 32'd6, 0, 0, lat, stalls, got);
    total++;
    if (o_div_zero !== 1'b0 || o_hi !== 32'd0 || o_lo !== 32'd30) begin
      bad++; $display("[TB] FAIL divzero_clear: got dz=%b hi=%h lo=%h, want 0 00000000 0000001e",
                      o_div_zero, o_hi, o_lo);
    end
  endtask

  task automatic test_cancel();
    int lat, stalls; logic got;
    run_op(MD_DIVU, 32'd1000, 32'd7, 10, 1, lat, stalls, got);
    total++;
    if (got !== 1'b0 || stalls !== 11 || o_stall_req !== 1'b0) begin
      bad++; $display("[TB] FAIL cancel_abort: got done_seen=%b stalls=%0d stall=%b, want 0 11 0",
                      got, stalls, o_stall_req);
    end
    total++;
    if (o_hi !== 32'd0 || o_lo !== 32'd30) begin
      bad++; $display("[TB] FAIL cancel_keep: got hi=%h lo=%h, want 00000000 0000001e", o_hi, o_lo);
    end
    @(negedge clk);
    i_start = 1'b1; i_cancel = 1'b1; i_op = MD_MULTU; i_opa = 32'd9; i_opb = 32'd9;
    @(negedge clk);
    i_start = 1'b0; i_cancel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (o_stall_req !== 1'b0 || o_done !== 1'b0 || o_lo !== 32'd30) begin
      bad++; $display("[TB] FAIL cancel_start_drop: got stall=%b done=%b lo=%h, want 0 0 0000001e",
                      o_stall_req, o_done, o_lo);
    end
    run_op(MD_DIVU, 32'd1000, 32'd7, 0, 0, lat, stalls, got);
    total++;
    if (lat !== 34 || o_lo !== 32'd142 || o_hi !== 32'd6) begin
      bad++; $display("[TB] FAIL cancel_reissue: got lat=%0d lo=%0d hi=%0d, want 34 142 6", lat, o_lo, o_hi);
    end
  endtask

  task automatic test_busy_start_and_reset();
    int lat, stalls; logic got;
    run_op(MD_DIVU, 32'd999, 32'd10, 5, 2, lat, stalls, got);
    total++;
    if (lat !== 34 || o_lo !== 32'd99 || o_hi !== 32'd9) begin
      bad++; $display("[TB] FAIL busy_start_ignored: got lat=%0d lo=%0d hi=%0d, want 34 99 9", lat, o_lo, o_hi);
    end
    @(negedge clk);
    i_start = 1'b1; i_op = MD_DIV; i_opa = 32'd1000; i_opb = 32'd7;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({o_hi, o_lo, o_done, o_div_zero, o_stall_req} !== 67'd0) begin
      bad++; $display("[TB] FAIL reset_mid_div: got hi=%h lo=%h done=%b dz=%b stall=%b, want all 0",
                      o_hi, o_lo, o_done, o_div_zero, o_stall_req);
    end
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    got = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (o_done || o_stall_req) got = 1'b1;
    end
    total++;
    if (got !== 1'b0 || o_lo !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_idle_after: got activity=%b lo=%h, want 0 00000000", got, o_lo);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_opa = '0; i_opb = '0; i_cancel = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div_signed();
    test_div_zero();
    test_cancel();
    test_busy_start_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
